// File: rtl/keypad_scan_rx.sv
// keypad_scan_rx: scans a 4x4 active-low hex keypad, debounces press/release, hands digits over valid/ack and keeps the last eight in entry.
module keypad_scan_rx #(
  parameter int SCAN_HOLD       = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic        new_clk,
  input  logic        rst,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic [31:0] entry,
  input  logic        entry_clr,
  output logic        overrun
);
  localparam int HW = $clog2(SCAN_HOLD);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  // nibble {row,col} holds the hex digit printed on that key
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t state;
  logic [3:0] row_m, row_s, code;
  logic [1:0] cidx, ridx, low_row;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] deb_cnt;
  logic bit_low, deb_end, accept, drop;
  always_comb begin
    bit_low = !row_s[ridx];
    deb_end = deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
    accept  = state == DEBOUNCE && bit_low && deb_end;
    drop    = accept && key_valid && !key_ack;
    code    = KEY_MAP[{ridx, cidx, 2'b00} +: 4];
    low_row = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
  end
  always_ff @(posedge new_clk) begin
    if (rst) begin
      state     <= SCAN;
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      col       <= 4'b1110;
      cidx      <= 2'd0;
      ridx      <= 2'd0;
      hold_cnt  <= '0;
      deb_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      entry     <= 32'h0;
      overrun   <= 1'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      case (state)
        SCAN:
          if (hold_cnt != HW'(SCAN_HOLD - 1)) hold_cnt <= hold_cnt + 1'b1;
          else if (&row_s) begin
            hold_cnt <= '0;
            col      <= {col[2:0], col[3]};
            cidx     <= cidx + 1'b1;
          end else begin
            hold_cnt <= '0;
            ridx     <= low_row;
            deb_cnt  <= '0;
            state    <= DEBOUNCE;
          end
        DEBOUNCE:
          if (!bit_low) begin
            state <= SCAN;
            col   <= {col[2:0], col[3]};
            cidx  <= cidx + 1'b1;
          end else if (deb_end) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else deb_cnt <= deb_cnt + 1'b1;
        PRESSED:
          if (bit_low) deb_cnt <= '0;
          else if (deb_end) begin
            state <= SCAN;
            col   <= {col[2:0], col[3]};
            cidx  <= cidx + 1'b1;
          end else deb_cnt <= deb_cnt + 1'b1;
        default: state <= SCAN;
      endcase
      if (accept && !drop) begin
        key_code  <= code;
        key_valid <= 1'b1;
      end else if (key_ack) key_valid <= 1'b0;
      overrun <= drop | (overrun & !entry_clr);
      if (accept) entry <= {entry_clr ? 28'h0 : entry[27:0], code};
      else if (entry_clr) entry <= 32'h0;
    end
  end
endmodule

// File: doc/keypad_scan_rx.md
Name: keypad_scan_rx

Overview:
- Input-side counterpart to the board's scanned 7-segment output path: it scans a 4x4 hex matrix keypad instead of driving a display.
- Drives one active-low column strobe at a time, reads the active-low row lines, and debounces press and release.
- Encodes each press to a 4-bit hex digit (the inverse of the hex-to-segment decode) and hands it to the core over a valid/ack handshake.
- Keeps the last eight digits in a 32-bit entry register.
- Runs in the divided display clock domain.

Parameters:
- SCAN_HOLD, 4, new_clk cycles each column stays strobed; minimum 3, to cover synchronizer latency.
- DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to accept a press and, separately, a release; minimum 1.

Ports:
- new_clk  in  1  divided display clock.
- rst  in  1  synchronous, active-high reset.
- col  out  4  column strobes, active-low, exactly one bit low.
- row  in  4  keypad rows, active-low, externally pulled up; asynchronous.
- key_code  out  4  hex code of the last accepted key.
- key_valid  out  1  key_code holds an unconsumed key.
- key_ack  in  1  consumer takes key_code; only meaningful while key_valid=1.
- entry  out  32  last eight accepted digits; newest digit in [3:0].
- entry_clr  in  1  synchronously clears entry and overrun.
- overrun  out  1  sticky flag: a key was dropped because key_valid was still pending.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock new_clk.
- Reset values:
  - col=4'b1110, key_code=0, key_valid=0, entry=0, overrun=0.
  - FSM=SCAN, hold and debounce counters=0, 2-flop row synchronizer=4'b1111.
- Reset mid-press or mid-debounce discards everything. Scanning restarts at column 0.
- Row synchronization: row passes through a 2-flop synchronizer, giving row_s. All decisions use row_s only.
- Key code map (row r, col c):
  - r0 -> 1,2,3,A
  - r1 -> 4,5,6,B
  - r2 -> 7,8,9,C
  - r3 -> E(*),0,F(#),D
- FSM state SCAN:
  - hold_cnt counts 0..SCAN_HOLD-1.
  - The sample point is hold_cnt==SCAN_HOLD-1.
  - At the sample point with row_s==4'hF: col rotates 1110->1101->1011->0111->1110 and hold_cnt clears.
  - At the sample point with any row_s bit low: latch the column index and the lowest-numbered low row, clear deb_cnt, go to DEBOUNCE. col stays frozen.
- FSM state DEBOUNCE:
  - Each cycle the latched row_s bit is low, deb_cnt increments.
  - If that bit is seen high, go to SCAN and advance to the next column. Nothing is emitted.
  - On the cycle deb_cnt reaches DEBOUNCE_CYCLES-1 with the bit still low: accept the key and go to PRESSED.
  - Timing: sample at cycle T means key_valid=1 from cycle T+DEBOUNCE_CYCLES+1.
- FSM state PRESSED:
  - col stays frozen.
  - deb_cnt counts consecutive cycles with the latched row_s bit high, and clears on any low cycle.
  - At DEBOUNCE_CYCLES, go to SCAN and advance to the next column.
  - Holding a key never auto-repeats.
- Accept rules:
  - If key_valid=0, or key_ack=1 in the same cycle: key_code<=code and key_valid<=1.
  - Otherwise the key is dropped: key_code is unchanged and overrun<=1. entry still shifts.
  - Every accept does entry <= {entry[27:0], code}. After eight digits the oldest digit falls off.
- Handshake:
  - key_ack with key_valid=1 and no simultaneous accept clears key_valid in the next cycle.
  - key_ack with key_valid=0 is ignored.
- entry_clr:
  - Sets entry<=0 and overrun<=0.
  - If an accept occurs in the same cycle: entry<={28'b0,code}, and overrun reflects only that cycle's drop.
- Multiple keys:
  - Only keys in the scanned column are seen. The lowest row index wins.
  - A second key pressed while in PRESSED is ignored until release.

Test Plan:
- Reset, no keys -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid=0, entry=0.
- Model key r1c2 (row[1]=col[2]), held 40 cycles -> exactly one accept, key_code=4'h6. key_valid rises 9 cycles after the column-2 sample point and stays high until key_ack, then falls the next cycle. entry=32'h6.
- Press r0c0 with 3-cycle bounce (row[0] toggling) before a stable hold -> no accept during bounce, then one accept of 4'h1. A release bounce of fewer than 8 cycles produces no second key.
- Press 1,2,3,A,4,5,6,B,7, each acked -> entry=32'h23A456B7; key_code=4'h7.
- Press 5 and do not ack, then press 9 -> key_code stays 4'h5, overrun=1, entry=32'h59. Then pulse entry_clr -> entry=0, overrun=0, key_valid stays 1.
- Hold r2c3 and r3c3 together -> code C only. Assert rst during DEBOUNCE -> no key_valid; col=1110 on the next cycle.
